multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Multi-cycle successor to the single-cycle combinational control unit for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/execute/memory/writeback states and drives all datapath enables and mux selects.
- Waits on a memory-ready handshake, with an optional timeout.
- Flags illegal opcodes and counts retired instructions.
- Opcode width and opcode encodings are parameters.

Parameters:
- OP_WIDTH, 3: opcode field width.
- OP_R, 3'b000: R-type.
- OP_LW, 3'b100: load word.
- OP_SW, 3'b101: store word.
- OP_BEQ, 3'b110: branch-equal.
- OP_ADDI, 3'b111: add immediate.
- OP_J, 3'b001: jump.
- CNT_WIDTH, 16: retireCount width.
- WAIT_LIMIT, 15: max consecutive memReady=0 cycles in a memory state before fault; 0 disables the timeout. WAIT_LIMIT < 2^8.

Ports:
- clk  in  1  clock, all state on rising edge
- rstN  in  1  asynchronous active-low reset
- enable  in  1  permits starting a new instruction
- opCode  in  OP_WIDTH  instruction opcode from IR, valid from DECODE on
- memReady  in  1  memory completes the current access this cycle
- pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, memtoReg, regDst, regWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  ALU B select
- ALUOp  out  2  ALU op class
- pcSource  out  2  PC mux select
- state  out  4  current state, for debug
- instrRetired  out  1  one-cycle pulse in the final cycle of an instruction
- illegalOp  out  1  one-cycle pulse, undefined opcode
- memFault  out  1  one-cycle pulse, wait timeout
- retireCount  out  CNT_WIDTH  retired instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Control outputs are combinational decodes of state (plus memReady where noted). Any output not listed for a state is 0.
- Reset (rstN=0, asynchronous): state=IDLE, retireCount=0, wait counter=0. All outputs are 0 and remain 0 while in IDLE.
- IDLE: next state FETCH if enable=1, else stay in IDLE.
- FETCH: memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, pcSource=00, irWrite=pcWrite=memReady. Stays in FETCH until memReady=1, then goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00. opCode is sampled here and selects the next state:
  - R -> EXEC
  - LW or SW -> MEMADR
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - Any other opcode: illegalOp=1, no retire, next state is the end-of-instruction state (below).
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: memRead=1, iorD=1. Holds until memReady=1, then MEMWB.
- MEMWB: memtoReg=1, regWrite=1. Retires.
- MEMWR: memWrite=1, iorD=1. Holds until memReady=1; retires in the memReady cycle.
- EXEC: ALUSrcA=1, ALUOp=10. Next state RWB.
- RWB: regDst=1, regWrite=1. Retires.
- BRANCH: ALUSrcA=1, ALUOp=01, pcWriteCond=1, pcSource=01. Retires.
- JUMP: pcWrite=1, pcSource=10. Retires.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: regWrite=1. Retires.
- Retire cycle: instrRetired=1. retireCount increments at the closing edge and wraps from 2^CNT_WIDTH-1 to 0.
- End-of-instruction state: after a retire, illegal op, or fault, next state is FETCH if enable=1, else IDLE. enable is ignored mid-instruction.
- Latency with memReady always 1 (cycles from FETCH entry to retire, inclusive): R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3.
- Timeout:
  - Wait counter increments on each cycle in FETCH, MEMRD or MEMWR with memReady=0, and clears on any state change.
  - When WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with memReady still 0: memFault=1 that cycle, all writes suppressed (irWrite, pcWrite, regWrite, memWrite = 0), next state IDLE, no retire.
  - If memReady=1 in the same cycle, the access completes normally and no fault is raised.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. retireCount is cleared.

Test Plan:
- Reset, enable=1, memReady=1, opCode=000 -> state sequence 1,2,7,8,1. regWrite=1 and regDst=1 only in RWB. instrRetired pulses once. retireCount=1.
- opCode 100, then 101, then 110, then 111, then 001, memReady=1 -> retire spacing of 5,4,3,4,3 cycles. BRANCH has pcWriteCond=1, pcSource=01. JUMP has pcSource=10. retireCount=5.
- LW with memReady=0 for 3 cycles in MEMRD -> state stays at 4 for 4 cycles. memRead=1 and iorD=1 throughout. Then MEMWB with memtoReg=1.
- WAIT_LIMIT=15, memReady held 0 in FETCH -> memFault pulses in cycle 16 of FETCH, irWrite=0 in that cycle, state goes to 0, retireCount unchanged.
- opCode=010 in DECODE -> illegalOp pulses once, no regWrite/memWrite/pcWrite, instrRetired=0. Next state is 1 if enable=1, 0 if enable=0.
- CNT_WIDTH=2, run 5 J instructions -> retireCount sequence 1,2,3,0,1. Assert rstN=0 mid-EXEC -> state=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: sequences each instruction through fetch, decode,
// execute, memory and writeback states, and drives the datapath enables and mux selects.
// Memory accesses wait on memReady, with an optional timeout that raises memFault.
module multi_cycle_control #(
   parameter int unsigned          OP_WIDTH   = 3,
   parameter logic [OP_WIDTH-1:0]  OP_R       = 3'b000,
   parameter logic [OP_WIDTH-1:0]  OP_LW      = 3'b100,
   parameter logic [OP_WIDTH-1:0]  OP_SW      = 3'b101,
   parameter logic [OP_WIDTH-1:0]  OP_BEQ     = 3'b110,
   parameter logic [OP_WIDTH-1:0]  OP_ADDI    = 3'b111,
   parameter logic [OP_WIDTH-1:0]  OP_J       = 3'b001,
   parameter int unsigned          CNT_WIDTH  = 16,
   parameter int unsigned          WAIT_LIMIT = 15
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 enable,
   input  logic [OP_WIDTH-1:0]  opCode,
   input  logic                 memReady,
   output logic                 pcWrite,
   output logic                 pcWriteCond,
   output logic                 irWrite,
   output logic                 iorD,
   output logic                 memRead,
   output logic                 memWrite,
   output logic                 memtoReg,
   output logic                 regDst,
   output logic                 regWrite,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic [1:0]           pcSource,
   output logic [3:0]           state,
   output logic                 instrRetired,
   output logic                 illegalOp,
   output logic                 memFault,
   output logic [CNT_WIDTH-1:0] retireCount
);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StExec   = 4'd7,
      StRwb    = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10,
      StAddiEx = 4'd11,
      StAddiWb = 4'd12
   } state_e;

   localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

   state_e               state_q, state_d;
   logic [7:0]           wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
   // Remembers whether the memory instruction decoded as a store (MEMADR branches on it).
   logic                 is_store_q, is_store_d;

   logic   wait_active;
   logic   timeout;
   state_e end_state;

   assign state       = state_q;
   assign retireCount = retire_cnt_q;

   // Next-state, datapath control decode, wait counter and retire counter.
   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      wait_cnt_d   = wait_cnt_q;
      retire_cnt_d = retire_cnt_q;

      pcWrite      = 1'b0;
      pcWriteCond  = 1'b0;
      irWrite      = 1'b0;
      iorD         = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memtoReg     = 1'b0;
      regDst       = 1'b0;
      regWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      pcSource     = 2'b00;
      instrRetired = 1'b0;
      illegalOp    = 1'b0;
      memFault     = 1'b0;

      wait_active = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
      // A ready in the limit cycle wins over the timeout.
      timeout     = (WAIT_LIMIT != 0) && wait_active && !memReady && (wait_cnt_q == WaitLimit);
      end_state   = enable ? StFetch : StIdle;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StFetch;
         end
         StFetch: begin
            memRead = 1'b1;
            ALUSrcB = 2'b01;
            irWrite = memReady;
            pcWrite = memReady;
            if (timeout) begin
               memFault = 1'b1;
               state_d  = StIdle;
            end else if (memReady) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            is_store_d = (opCode == OP_SW);
            if (opCode == OP_R) begin
               state_d = StExec;
            end else if (opCode == OP_LW || opCode == OP_SW) begin
               state_d = StMemAdr;
            end else if (opCode == OP_BEQ) begin
               state_d = StBranch;
            end else if (opCode == OP_ADDI) begin
               state_d = StAddiEx;
            end else if (opCode == OP_J) begin
               state_d = StJump;
            end else begin
               illegalOp = 1'b1;
               state_d   = end_state;
            end
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = is_store_q ? StMemWr : StMemRd;
         end
         StMemRd: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (timeout) begin
               memFault = 1'b1;
               state_d  = StIdle;
            end else if (memReady) begin
               state_d = StMemWb;
            end
         end
         StMemWb: begin
            memtoReg     = 1'b1;
            regWrite     = 1'b1;
            instrRetired = 1'b1;
            state_d      = end_state;
         end
         StMemWr: begin
            iorD     = 1'b1;
            memWrite = !timeout;
            if (timeout) begin
               memFault = 1'b1;
               state_d  = StIdle;
            end else if (memReady) begin
               instrRetired = 1'b1;
               state_d      = end_state;
            end
         end
         StExec: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = StRwb;
         end
         StRwb: begin
            regDst       = 1'b1;
            regWrite     = 1'b1;
            instrRetired = 1'b1;
            state_d      = end_state;
         end
         StBranch: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 2'b01;
            pcWriteCond  = 1'b1;
            pcSource     = 2'b01;
            instrRetired = 1'b1;
            state_d      = end_state;
         end
         StJump: begin
            pcWrite      = 1'b1;
            pcSource     = 2'b10;
            instrRetired = 1'b1;
            state_d      = end_state;
         end
         StAddiEx: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            regWrite     = 1'b1;
            instrRetired = 1'b1;
            state_d      = end_state;
         end
         default: state_d = StIdle;
      endcase

      if (instrRetired) retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);

      // Count consecutive not-ready cycles in one wait state; saturate so it never wraps.
      if (state_d != state_q) begin
         wait_cnt_d = 8'd0;
      end else if (wait_active && !memReady && wait_cnt_q != 8'hFF) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   // State and counter registers; reset returns to IDLE immediately.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= StIdle;
         wait_cnt_q   <= 8'd0;
         retire_cnt_q <= '0;
         is_store_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         is_store_q   <= is_store_d;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and retire-counter wrap.
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       rstN, enable, memReady;
   logic [2:0] opCode;

   logic        pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, memtoReg;
   logic        regDst, regWrite, ALUSrcA, instrRetired, illegalOp, memFault;
   logic [1:0]  ALUSrcB, ALUOp, pcSource;
   logic [3:0]  state;
   logic [15:0] retireCount;

   logic        d2_pcWrite, d2_pcWriteCond, d2_irWrite, d2_iorD, d2_memRead, d2_memWrite;
   logic        d2_memtoReg, d2_regDst, d2_regWrite, d2_ALUSrcA, d2_instrRetired;
   logic        d2_illegalOp, d2_memFault;
   logic [1:0]  d2_ALUSrcB, d2_ALUOp, d2_pcSource;
   logic [3:0]  d2_state;
   logic [1:0]  d2_retireCount;

   always #5 clk = ~clk;

   multi_cycle_control dut (
      .clk(clk), .rstN(rstN), .enable(enable), .opCode(opCode), .memReady(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite), .iorD(iorD),
      .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg), .regDst(regDst),
      .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .pcSource(pcSource), .state(state), .instrRetired(instrRetired),
      .illegalOp(illegalOp), .memFault(memFault), .retireCount(retireCount)
   );

   // Narrow-counter instance sharing all stimulus, used to check counter wrap.
   multi_cycle_control #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rstN(rstN), .enable(enable), .opCode(opCode), .memReady(memReady),
      .pcWrite(d2_pcWrite), .pcWriteCond(d2_pcWriteCond), .irWrite(d2_irWrite),
      .iorD(d2_iorD), .memRead(d2_memRead), .memWrite(d2_memWrite),
      .memtoReg(d2_memtoReg), .regDst(d2_regDst), .regWrite(d2_regWrite),
      .ALUSrcA(d2_ALUSrcA), .ALUSrcB(d2_ALUSrcB), .ALUOp(d2_ALUOp),
      .pcSource(d2_pcSource), .state(d2_state), .instrRetired(d2_instrRetired),
      .illegalOp(d2_illegalOp), .memFault(d2_memFault), .retireCount(d2_retireCount)
   );

   // {pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, memtoReg, regDst, regWrite,
   //  ALUSrcA, ALUSrcB, ALUOp, pcSource, instrRetired, illegalOp, memFault}
   logic [18:0] act_cw;
   assign act_cw = {pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, memtoReg, regDst,
                    regWrite, ALUSrcA, ALUSrcB, ALUOp, pcSource, instrRetired, illegalOp,
                    memFault};

   localparam logic [18:0] CW_IDLE    = 19'b0;
   localparam logic [18:0] CW_FETCH_R = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b0,
                                         2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] CW_FETCH_W = {4'b0, 1'b1, 5'b0, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] CW_FETCH_F = {4'b0, 1'b1, 5'b0, 2'b01, 2'b00, 2'b00, 3'b001};
   localparam logic [18:0] CW_DECODE  = {10'b0, 2'b11, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] CW_DEC_ILL = {10'b0, 2'b11, 2'b00, 2'b00, 3'b010};
   localparam logic [18:0] CW_MEMADR  = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] CW_MEMRD   = {3'b0, 1'b1, 1'b1, 5'b0, 6'b0, 3'b000};
   localparam logic [18:0] CW_MEMWB   = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 3'b100};
   localparam logic [18:0] CW_MEMWR_R = {3'b0, 1'b1, 1'b0, 1'b1, 4'b0, 6'b0, 3'b100};
   localparam logic [18:0] CW_MEMWR_W = {3'b0, 1'b1, 1'b0, 1'b1, 4'b0, 6'b0, 3'b000};
   localparam logic [18:0] CW_MEMWR_F = {3'b0, 1'b1, 6'b0, 6'b0, 3'b001};
   localparam logic [18:0] CW_EXEC    = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00, 3'b000};
   localparam logic [18:0] CW_RWB     = {7'b0, 1'b1, 1'b1, 1'b0, 6'b0, 3'b100};
   localparam logic [18:0] CW_BRANCH  = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 3'b100};
   localparam logic [18:0] CW_JUMP    = {1'b1, 9'b0, 2'b00, 2'b00, 2'b10, 3'b100};
   localparam logic [18:0] CW_ADDIWB  = {8'b0, 1'b1, 1'b0, 6'b0, 3'b100};

   localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
   localparam logic [3:0] S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10;
   localparam logic [3:0] S_ADDIEX = 4'd11, S_ADDIWB = 4'd12;

   typedef struct {
      logic        en;
      logic        rdy;
      logic [2:0]  op;
      logic [3:0]  st;
      logic [18:0] cw;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s #%0d: got %h, want %h", name, idx, act, exp);
      end
   endtask

   function automatic void add(input logic en, input logic rdy, input logic [2:0] op,
                               input logic [3:0] st, input logic [18:0] cw,
                               input logic [15:0] cnt);
      vec_t v;
      v.en = en; v.rdy = rdy; v.op = op; v.st = st; v.cw = cw; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic check_all_zero(input string name);
      check({name, "_state"}, 0, 32'(state), 32'(S_IDLE));
      check({name, "_ctl"}, 0, 32'(act_cw), 32'(CW_IDLE));
      check({name, "_cnt"}, 0, 32'(retireCount), 32'd0);
      check({name, "_cnt2"}, 0, 32'(d2_retireCount), 32'd0);
   endtask

   logic [1:0] wrap_exp [5];

   initial begin
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // R, LW, SW, BEQ, ADDI, J back to back
      add(1, 1, 0, S_IDLE,   CW_IDLE,    0);
      add(1, 1, 0, S_FETCH,  CW_FETCH_R, 0);
      add(1, 1, 0, S_DECODE, CW_DECODE,  0);
      add(1, 1, 0, S_EXEC,   CW_EXEC,    0);
      add(1, 1, 0, S_RWB,    CW_RWB,     0);
      add(1, 1, 4, S_FETCH,  CW_FETCH_R, 1);
      add(1, 1, 4, S_DECODE, CW_DECODE,  1);
      add(1, 1, 4, S_MEMADR, CW_MEMADR,  1);
      add(1, 1, 4, S_MEMRD,  CW_MEMRD,   1);
      add(1, 1, 4, S_MEMWB,  CW_MEMWB,   1);
      add(1, 1, 5, S_FETCH,  CW_FETCH_R, 2);
      add(1, 1, 5, S_DECODE, CW_DECODE,  2);
      add(1, 1, 5, S_MEMADR, CW_MEMADR,  2);
      add(1, 1, 5, S_MEMWR,  CW_MEMWR_R, 2);
      add(1, 1, 6, S_FETCH,  CW_FETCH_R, 3);
      add(1, 1, 6, S_DECODE, CW_DECODE,  3);
      add(1, 1, 6, S_BRANCH, CW_BRANCH,  3);
      add(1, 1, 7, S_FETCH,  CW_FETCH_R, 4);
      add(1, 1, 7, S_DECODE, CW_DECODE,  4);
      add(1, 1, 7, S_ADDIEX, CW_MEMADR,  4);
      add(1, 1, 7, S_ADDIWB, CW_ADDIWB,  4);
      add(1, 1, 1, S_FETCH,  CW_FETCH_R, 5);
      add(1, 1, 1, S_DECODE, CW_DECODE,  5);
      add(1, 1, 1, S_JUMP,   CW_JUMP,    5);
      // LW with three not-ready cycles in MEMRD
      add(1, 1, 4, S_FETCH,  CW_FETCH_R, 6);
      add(1, 1, 4, S_DECODE, CW_DECODE,  6);
      add(1, 1, 4, S_MEMADR, CW_MEMADR,  6);
      add(1, 0, 4, S_MEMRD,  CW_MEMRD,   6);
      add(1, 0, 4, S_MEMRD,  CW_MEMRD,   6);
      add(1, 0, 4, S_MEMRD,  CW_MEMRD,   6);
      add(1, 1, 4, S_MEMRD,  CW_MEMRD,   6);
      add(1, 1, 4, S_MEMWB,  CW_MEMWB,   6);
      // illegal opcode with enable low, then high; enable ignored mid-instruction
      add(1, 1, 2, S_FETCH,  CW_FETCH_R, 7);
      add(0, 1, 2, S_DECODE, CW_DEC_ILL, 7);
      add(1, 1, 2, S_IDLE,   CW_IDLE,    7);
      add(1, 1, 2, S_FETCH,  CW_FETCH_R, 7);
      add(1, 1, 2, S_DECODE, CW_DEC_ILL, 7);
      add(0, 1, 1, S_FETCH,  CW_FETCH_R, 7);
      add(0, 1, 1, S_DECODE, CW_DECODE,  7);
      add(0, 1, 1, S_JUMP,   CW_JUMP,    7);
      add(0, 1, 1, S_IDLE,   CW_IDLE,    8);
      add(0, 1, 1, S_IDLE,   CW_IDLE,    8);
      // SW with a fetch wait and a store wait
      add(1, 1, 5, S_IDLE,   CW_IDLE,    8);
      add(0, 0, 5, S_FETCH,  CW_FETCH_W, 8);
      add(1, 1, 5, S_FETCH,  CW_FETCH_R, 8);
      add(1, 1, 5, S_DECODE, CW_DECODE,  8);
      add(1, 1, 5, S_MEMADR, CW_MEMADR,  8);
      add(1, 0, 5, S_MEMWR,  CW_MEMWR_W, 8);
      add(0, 1, 5, S_MEMWR,  CW_MEMWR_R, 8);
      add(0, 1, 5, S_IDLE,   CW_IDLE,    9);
      // fetch timeout: fault in the 16th not-ready FETCH cycle, then IDLE
      add(1, 0, 0, S_IDLE,   CW_IDLE,    9);
      for (int k = 0; k < 15; k++) add(1, 0, 0, S_FETCH, CW_FETCH_W, 9);
      add(1, 0, 0, S_FETCH,  CW_FETCH_F, 9);
      add(0, 1, 0, S_IDLE,   CW_IDLE,    9);
      // ready in the limit cycle completes normally
      add(1, 0, 1, S_IDLE,   CW_IDLE,    9);
      for (int k = 0; k < 15; k++) add(1, 0, 1, S_FETCH, CW_FETCH_W, 9);
      add(1, 1, 1, S_FETCH,  CW_FETCH_R, 9);
      add(1, 1, 1, S_DECODE, CW_DECODE,  9);
      add(0, 1, 1, S_JUMP,   CW_JUMP,    9);
      add(0, 1, 1, S_IDLE,   CW_IDLE,    10);
      // store timeout: memWrite suppressed, IDLE even with enable high
      add(1, 1, 5, S_IDLE,   CW_IDLE,    10);
      add(1, 1, 5, S_FETCH,  CW_FETCH_R, 10);
      add(1, 1, 5, S_DECODE, CW_DECODE,  10);
      add(1, 1, 5, S_MEMADR, CW_MEMADR,  10);
      for (int k = 0; k < 15; k++) add(1, 0, 5, S_MEMWR, CW_MEMWR_W, 10);
      add(1, 0, 5, S_MEMWR,  CW_MEMWR_F, 10);
      add(0, 1, 5, S_IDLE,   CW_IDLE,    10);

      // reset state
      rstN = 1'b0; enable = 1'b0; memReady = 1'b0; opCode = 3'd0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rstN = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         enable = vecs[i].en; memReady = vecs[i].rdy; opCode = vecs[i].op;
         #1;
         check("state", i, 32'(state), 32'(vecs[i].st));
         check("ctl", i, 32'(act_cw), 32'(vecs[i].cw));
         check("retire_cnt", i, 32'(retireCount), 32'(vecs[i].cnt));
         check("retire_cnt2", i, 32'(d2_retireCount), 32'(vecs[i].cnt[1:0]));
      end

      // asynchronous reset in the middle of EXEC
      @(negedge clk);
      enable = 1'b1; memReady = 1'b1; opCode = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      check("pre_rst_state", 0, 32'(state), 32'(S_EXEC));
      #1;
      rstN = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rstN = 1'b1;
      enable = 1'b1; memReady = 1'b1; opCode = 3'd1;

      // five jumps: narrow counter wraps 1,2,3,0,1
      for (int j = 0; j < 5; j++) begin
         repeat ((j == 0) ? 4 : 3) @(posedge clk);
         #1;
         check("wrap_state", j, 32'(state), 32'(S_FETCH));
         check("wrap_cnt", j, 32'(retireCount), 32'(j + 1));
         check("wrap_cnt2", j, 32'(d2_retireCount), 32'(wrap_exp[j]));
      end
      enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
